// File: rtl/hud_turn_controller_if.sv
// rtl/hud_turn_controller_if.sv - event inputs and BCD display outputs of the HUD turn controller
//
// Purpose: bundles the game-logic event pulses and the HEX-decoder-facing
// BCD digits of hud_turn_controller into one interface.
// Signals:
//   start, match_found, mismatch : single-cycle event pulses from game logic
//   p1_score, p2_score           : player scores, BCD 0..9
//   cur_player                   : 4'h1 or 4'h2
//   timer_tens, timer_ones       : countdown digits, BCD
//   winner                       : 4'h1 / 4'h2 winner, 4'h0 none or tie
//   game_over                    : high while the game is finished
// Modports: master drives the events (game logic / bench), slave is the controller.

interface hud_turn_controller_if;
    logic       start;
    logic       match_found;
    logic       mismatch;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [3:0] cur_player;
    logic [3:0] timer_tens;
    logic [3:0] timer_ones;
    logic [3:0] winner;
    logic       game_over;

    modport master (
        output start, match_found, mismatch,
        input  p1_score, p2_score, cur_player, timer_tens, timer_ones, winner, game_over
    );

    modport slave (
        input  start, match_found, mismatch,
        output p1_score, p2_score, cur_player, timer_tens, timer_ones, winner, game_over
    );
endinterface

// File: rtl/hud_turn_controller.sv
// rtl/hud_turn_controller.sv - turn, countdown, score and winner sequencing for the game HUD
//
// Purpose: tracks the current player, runs the per-turn BCD countdown,
// accumulates both scores and decides the winner once all pairs are found.
// Ports:
//   i_clk  : system clock, rising edge
//   i_rst  : asynchronous active-high reset
//   io_hud : slave side of hud_turn_controller_if (event pulses in, BCD digits out)
// All outputs come straight from registers (or a decode of the state register).

module hud_turn_controller #(
    parameter int CLK_HZ       = 50000000,
    parameter int TURN_SECONDS = 15,
    parameter int TOTAL_PAIRS  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    hud_turn_controller_if.slave  io_hud
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX   = PW'(CLK_HZ - 1);
    localparam logic [3:0]    RELOAD_TENS = 4'(TURN_SECONDS / 10);
    localparam logic [3:0]    RELOAD_ONES = 4'(TURN_SECONDS % 10);
    localparam logic [4:0]    PAIRS       = 5'(TOTAL_PAIRS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t          r_state;
    logic [3:0]      r_p1;
    logic [3:0]      r_p2;
    logic            r_cur;      // 0 = player 1, 1 = player 2
    logic [3:0]      r_tens;
    logic [3:0]      r_ones;
    logic [3:0]      r_winner;
    logic [PW-1:0]   r_presc;

    state_t          w_state_nx;
    logic [3:0]      w_p1_nx;
    logic [3:0]      w_p2_nx;
    logic            w_cur_nx;
    logic [3:0]      w_tens_nx;
    logic [3:0]      w_ones_nx;
    logic [3:0]      w_winner_nx;
    logic [PW-1:0]   w_presc_nx;
    logic [4:0]      w_sum;
    logic            w_tick;

    assign w_tick = (r_presc == PRESC_MAX);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_p1     <= 4'd0;
            r_p2     <= 4'd0;
            r_cur    <= 1'b0;
            r_tens   <= RELOAD_TENS;
            r_ones   <= RELOAD_ONES;
            r_winner <= 4'd0;
            r_presc  <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_p1     <= w_p1_nx;
            r_p2     <= w_p2_nx;
            r_cur    <= w_cur_nx;
            r_tens   <= w_tens_nx;
            r_ones   <= w_ones_nx;
            r_winner <= w_winner_nx;
            r_presc  <= w_presc_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_p1_nx     = r_p1;
        w_p2_nx     = r_p2;
        w_cur_nx    = r_cur;
        w_tens_nx   = r_tens;
        w_ones_nx   = r_ones;
        w_winner_nx = r_winner;
        w_presc_nx  = r_presc;
        w_sum       = 5'd0;

        case (r_state)
            S_IDLE, S_OVER: begin
                // A new game starts from a clean slate whichever idle state we came from.
                if (io_hud.start) begin
                    w_state_nx  = S_PLAY;
                    w_p1_nx     = 4'd0;
                    w_p2_nx     = 4'd0;
                    w_cur_nx    = 1'b0;
                    w_tens_nx   = RELOAD_TENS;
                    w_ones_nx   = RELOAD_ONES;
                    w_winner_nx = 4'd0;
                    w_presc_nx  = '0;
                end
            end

            S_PLAY: begin
                w_presc_nx = w_tick ? '0 : r_presc + 1'b1;

                // Priority: match > mismatch > expiry > ordinary tick.
                if (io_hud.match_found) begin
                    if (!r_cur)
                        w_p1_nx = (r_p1 == 4'd9) ? 4'd9 : r_p1 + 4'd1;
                    else
                        w_p2_nx = (r_p2 == 4'd9) ? 4'd9 : r_p2 + 4'd1;
                    w_tens_nx  = RELOAD_TENS;
                    w_ones_nx  = RELOAD_ONES;
                    w_presc_nx = '0;
                    // Winner is judged on the post-increment scores so it lands
                    // in the same cycle as game_over.
                    w_sum = {1'b0, w_p1_nx} + {1'b0, w_p2_nx};
                    if (w_sum == PAIRS) begin
                        w_state_nx = S_OVER;
                        if (w_p1_nx > w_p2_nx)
                            w_winner_nx = 4'h1;
                        else if (w_p2_nx > w_p1_nx)
                            w_winner_nx = 4'h2;
                        else
                            w_winner_nx = 4'h0;
                    end
                end else if (io_hud.mismatch) begin
                    w_cur_nx   = ~r_cur;
                    w_tens_nx  = RELOAD_TENS;
                    w_ones_nx  = RELOAD_ONES;
                    w_presc_nx = '0;
                end else if (w_tick) begin
                    if (r_tens == 4'd0 && r_ones == 4'd0) begin
                        // 00 has been displayed for a full second: turn expires.
                        w_cur_nx  = ~r_cur;
                        w_tens_nx = RELOAD_TENS;
                        w_ones_nx = RELOAD_ONES;
                    end else if (r_ones != 4'd0) begin
                        w_ones_nx = r_ones - 4'd1;
                    end else begin
                        w_ones_nx = 4'd9;
                        w_tens_nx = r_tens - 4'd1;
                    end
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign io_hud.p1_score   = r_p1;
    assign io_hud.p2_score   = r_p2;
    assign io_hud.cur_player = r_cur ? 4'h2 : 4'h1;
    assign io_hud.timer_tens = r_tens;
    assign io_hud.timer_ones = r_ones;
    assign io_hud.winner     = r_winner;
    assign io_hud.game_over  = (r_state == S_OVER);

endmodule

// File: tb/tb_hud_turn_controller.sv
// tb/tb_hud_turn_controller.sv - directed self-checking bench for hud_turn_controller

module tb_hud_turn_controller;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic hold_ok;

    hud_turn_controller_if hud();

    hud_turn_controller #(
        .CLK_HZ       (4),
        .TURN_SECONDS (15),
        .TOTAL_PAIRS  (8)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_hud (hud)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag,
                           input logic [3:0] p1, input logic [3:0] p2, input logic [3:0] cur,
                           input logic [3:0] tens, input logic [3:0] ones,
                           input logic [3:0] win, input logic go);
        chk({tag, ".p1"},     hud.p1_score,   p1);
        chk({tag, ".p2"},     hud.p2_score,   p2);
        chk({tag, ".cur"},    hud.cur_player, cur);
        chk({tag, ".tens"},   hud.timer_tens, tens);
        chk({tag, ".ones"},   hud.timer_ones, ones);
        chk({tag, ".winner"}, hud.winner,     win);
        chk({tag, ".over"},   {3'b000, hud.game_over}, {3'b000, go});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic m, input logic mm);
        hud.start       = s;
        hud.match_found = m;
        hud.mismatch    = mm;
        step();
        hud.start       = 1'b0;
        hud.match_found = 1'b0;
        hud.mismatch    = 1'b0;
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        hud.start       = 1'b0;
        hud.match_found = 1'b0;
        hud.mismatch    = 1'b0;

        #2;
        chk_all("reset", 4'd0, 4'd0, 4'h1, 4'd1, 4'd5, 4'd0, 1'b0);
        step();
        rst = 1'b0;

        // IDLE without start: everything frozen for 100 cycles.
        hold_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (hud.p1_score !== 4'd0 || hud.p2_score !== 4'd0 || hud.cur_player !== 4'h1 ||
                hud.timer_tens !== 4'd1 || hud.timer_ones !== 4'd5 || hud.winner !== 4'd0 ||
                hud.game_over !== 1'b0)
                hold_ok = 1'b0;
        end
        chk("idle_hold", {3'b000, hold_ok}, 4'd1);

        pulse(1'b1, 1'b0, 1'b0);
        chk_all("play_entry", 4'd0, 4'd0, 4'h1, 4'd1, 5, 4'd0, 1'b0);
        repeat (4) step();
        chk_all("first_tick", 4'd0, 4'd0, 4'h1, 4'd1, 4'd4, 4'd0, 1'b0);

        // start during PLAY must not reload the timer or prescaler.
        pulse(1'b1, 1'b0, 1'b0);
        chk_all("start_in_play", 4'd0, 4'd0, 4'h1, 4'd1, 4'd4, 4'd0, 1'b0);
        repeat (19) step();
        chk_all("tens_borrow", 4'd0, 4'd0, 4'h1, 4'd0, 4'd9, 4'd0, 1'b0);
        repeat (36) step();
        chk_all("at_zero", 4'd0, 4'd0, 4'h1, 4'd0, 4'd0, 4'd0, 1'b0);
        repeat (4) step();
        chk_all("expiry", 4'd0, 4'd0, 4'h2, 4'd1, 4'd5, 4'd0, 1'b0);

        pulse(1'b0, 1'b0, 1'b1);
        chk_all("mismatch_back_p1", 4'd0, 4'd0, 4'h1, 4'd1, 4'd5, 4'd0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        chk_all("p1_match", 4'd1, 4'd0, 4'h1, 4'd1, 4'd5, 4'd0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        chk_all("p1_mismatch", 4'd1, 4'd0, 4'h2, 4'd1, 4'd5, 4'd0, 1'b0);
        pulse(1'b0, 1'b1, 1'b1);
        chk_all("match_beats_mismatch", 4'd1, 4'd1, 4'h2, 4'd1, 4'd5, 4'd0, 1'b0);

        // Run to 00 with the prescaler one short of a tick, then match on the expiry edge.
        repeat (63) step();
        chk_all("pre_expiry", 4'd1, 4'd1, 4'h2, 4'd0, 4'd0, 4'd0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        chk_all("match_beats_expiry", 4'd1, 4'd2, 4'h2, 4'd1, 4'd5, 4'd0, 1'b0);
        repeat (3) step();
        chk_all("presc_cleared", 4'd1, 4'd2, 4'h2, 4'd1, 4'd5, 4'd0, 1'b0);
        step();
        chk_all("tick_after_match", 4'd1, 4'd2, 4'h2, 4'd1, 4'd4, 4'd0, 1'b0);

        // Finish as 5/3 with player 1 winning.
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        repeat (3) pulse(1'b0, 1'b1, 1'b0);
        chk_all("sum7", 4'd4, 4'd3, 4'h1, 4'd1, 4'd5, 4'd0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        chk_all("p1_wins", 4'd5, 4'd3, 4'h1, 4'd1, 4'd5, 4'h1, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (10) step();
        chk_all("over_hold", 4'd5, 4'd3, 4'h1, 4'd1, 4'd5, 4'h1, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        chk_all("restart", 4'd0, 4'd0, 4'h1, 4'd1, 4'd5, 4'd0, 1'b0);

        // Tie at 4/4.
        repeat (4) pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        repeat (3) pulse(1'b0, 1'b1, 1'b0);
        chk_all("tie_sum7", 4'd4, 4'd3, 4'h2, 4'd1, 4'd5, 4'd0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        chk_all("tie", 4'd4, 4'd4, 4'h2, 4'd1, 4'd5, 4'd0, 1'b1);

        // Reset between clock edges mid-countdown.
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (32) step();
        chk_all("countdown_07", 4'd1, 4'd0, 4'h1, 4'd0, 4'd7, 4'd0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk_all("async_reset", 4'd0, 4'd0, 4'h1, 4'd1, 4'd5, 4'd0, 1'b0);
        step();
        rst = 1'b0;
        repeat (8) step();
        chk_all("idle_after_reset", 4'd0, 4'd0, 4'h1, 4'd1, 4'd5, 4'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
